// File: rtl/api_slave.sv
// api_slave: serial API responder. Deserializes 32-bit work words from sck/mosi and
// returns FIFO result blocks on miso. Build macro: API_SLAVE_LOOPBACK_EN (idle words echo input).
module api_slave #(
  parameter int WORK_LEN = 23,
  parameter int RESP_LEN = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_n,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        work_vld,
  output logic [4:0]  work_idx,
  output logic [31:0] work_dat,
  output logic        work_done,
  input  logic        res_empty,
  output logic        res_rd,
  input  logic [31:0] res_dat,
  output logic        busy,
  output logic        err_underrun,
  output logic        dbg_state
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [4:0] IDX_LAST = 5'(WORK_LEN - 1);
  localparam logic [4:0] RESP_END = 5'(RESP_LEN);

  state_t      state_q, state_d;
  logic [2:0]  sck_q, load_q;
  logic [1:0]  mosi_q;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic        armed_q, armed_d;
  logic        err_q, err_d;
  logic        work_vld_q, work_vld_d;
  logic        work_done_q, work_done_d;
  logic [4:0]  work_idx_q, work_idx_d;
  logic [31:0] work_dat_q, work_dat_d;
  logic        res_rd_q, res_rd_d;

  logic        rise_e, fall_e, sel_e, desel_e, mosi_s;
  logic [31:0] rx_word;
  logic [4:0]  next_idx, load_idx;
  logic        load_en, frame_start, armed_now;

  // Index [1] is the synchronized level, index [2] its previous value for edge detection.
  assign rise_e  =  sck_q[1] & ~sck_q[2];
  assign fall_e  = ~sck_q[1] &  sck_q[2];
  assign sel_e   = ~load_q[1] &  load_q[2];
  assign desel_e =  load_q[1] & ~load_q[2];
  assign mosi_s  = mosi_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q       <= 3'b000;
      load_q      <= 3'b111;
      mosi_q      <= 2'b00;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      armed_q     <= 1'b0;
      err_q       <= 1'b0;
      work_vld_q  <= 1'b0;
      work_done_q <= 1'b0;
      work_idx_q  <= '0;
      work_dat_q  <= '0;
      res_rd_q    <= 1'b0;
    end else begin
      sck_q       <= {sck_q[1:0], sck};
      load_q      <= {load_q[1:0], load_n};
      mosi_q      <= {mosi_q[0], mosi};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      rx_sr_q     <= rx_sr_d;
      tx_sr_q     <= tx_sr_d;
      armed_q     <= armed_d;
      err_q       <= err_d;
      work_vld_q  <= work_vld_d;
      work_done_q <= work_done_d;
      work_idx_q  <= work_idx_d;
      work_dat_q  <= work_dat_d;
      res_rd_q    <= res_rd_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idx_d       = idx_q;
    rx_sr_d     = rx_sr_q;
    tx_sr_d     = tx_sr_q;
    armed_d     = armed_q;
    err_d       = err_q;
    work_vld_d  = 1'b0;
    work_done_d = 1'b0;
    work_idx_d  = work_idx_q;
    work_dat_d  = work_dat_q;
    res_rd_d    = 1'b0;
    rx_word     = {rx_sr_q[30:0], mosi_s};
    next_idx    = (idx_q == IDX_LAST) ? 5'd0 : idx_q + 5'd1;
    load_en     = 1'b0;
    load_idx    = '0;
    frame_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sel_e) begin
          state_d     = SHIFT;
          bit_cnt_d   = '0;
          idx_d       = '0;
          load_en     = 1'b1;
          frame_start = 1'b1;
        end
      end
      SHIFT: begin
        if (desel_e) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          idx_d     = '0;
        end else if (rise_e) begin
          rx_sr_d = rx_word;
          if (bit_cnt_q == 5'd31) begin
            work_vld_d  = 1'b1;
            work_dat_d  = rx_word;
            work_idx_d  = idx_q;
            work_done_d = (idx_q == IDX_LAST);
            bit_cnt_d   = '0;
            idx_d       = next_idx;
            load_en     = 1'b1;
            load_idx    = next_idx;
            frame_start = (next_idx == 5'd0);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else if (fall_e && bit_cnt_q != 5'd0) begin
          // The fall that follows a word's last rise must not shift out the freshly loaded bit 31.
          tx_sr_d = {tx_sr_q[30:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase

    // res_dat is captured on the edge that raises res_rd; the FIFO pops at the end of that cycle.
    armed_now = frame_start ? ~res_empty : armed_q;
    if (load_en) begin
      armed_d = armed_now;
      if (load_idx < RESP_END) begin
        if (armed_now) begin
          if (res_empty) begin
            tx_sr_d = '0;
            err_d   = 1'b1;
          end else begin
            tx_sr_d  = res_dat;
            res_rd_d = 1'b1;
          end
        end else begin
`ifdef API_SLAVE_LOOPBACK_EN
          tx_sr_d = frame_start ? 32'h0 : rx_word;
`else
          tx_sr_d = 32'h0;
`endif
        end
      end else begin
        tx_sr_d = '0;
      end
    end
  end

  assign miso         = (state_q == SHIFT) ? tx_sr_q[31] : 1'b1;
  assign busy         = (state_q == SHIFT);
  assign dbg_state    = state_q;
  assign work_vld     = work_vld_q;
  assign work_done    = work_done_q;
  assign work_idx     = work_idx_q;
  assign work_dat     = work_dat_q;
  assign res_rd       = res_rd_q;
  assign err_underrun = err_q;

endmodule
